// File: rtl/led_stretcher_pkg.sv
// led_stretcher_pkg
// Shared definitions for the LED pulse stretcher:
//   - chanState_e : per-channel state encoding (IDLE=0, ON=1, GAP=2; 3 is illegal)
//   - MinCountWidth : smallest counter width ever used
//   - cntWidth()  : width of the per-channel down-counter for given on/off lengths
package led_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } chanState_e;

    localparam int MinCountWidth = 1;

    // The counter only ever holds (length - 1), so $clog2 of the longer
    // phase is enough; a one-cycle phase would give zero bits, hence the floor.
    function automatic int cntWidth(input int onCycles, input int offCycles);
        int longest;
        longest = (onCycles > offCycles) ? onCycles : offCycles;
        return ($clog2(longest) < MinCountWidth) ? MinCountWidth : $clog2(longest);
    endfunction

endpackage

// File: rtl/led_stretcher_chan.sv
// led_stretcher_chan
// One channel of the pulse stretcher: rising-edge detect, IDLE/ON/GAP state
// machine, phase down-counter and a single saturating pending flag.
// Ports:
//   clk_i   : clock, posedge
//   rst_ni  : asynchronous active-low reset
//   pulse_i : event input, synchronous to clk_i, any pulse width
//   led_o   : stretched output, registered
//   busy_o  : high while the channel is not IDLE, registered, aligned with led_o
module led_stretcher_chan #(
    parameter int on_cycles  = 4,
    parameter int off_cycles = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pulse_i,
    output logic led_o,
    output logic busy_o
);

    import led_stretcher_pkg::*;

    localparam int CountWidth = cntWidth(on_cycles, off_cycles);
    localparam logic [CountWidth-1:0] OnLoad  = CountWidth'(on_cycles - 1);
    localparam logic [CountWidth-1:0] OffLoad = CountWidth'(off_cycles - 1);
    localparam logic [CountWidth-1:0] CountOne = CountWidth'(1);

    chanState_e            state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  pend_q, pend_d;
    logic                  prevIn_q;
    logic                  led_q, led_d;
    logic                  busy_q, busy_d;
    logic                  risingEdge;

    // A held-high input must only ever count once, so events are the
    // 0->1 transitions against the previous sample.
    assign risingEdge = pulse_i & ~prevIn_q;

    // State register: FSM state, counter, pending flag, input history and
    // the registered outputs all drop together on reset so that a blink in
    // progress and any queued event are discarded at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            pend_q   <= 1'b0;
            prevIn_q <= 1'b0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            prevIn_q <= pulse_i;
            led_q    <= led_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic. The counter is loaded on entry to ON/GAP and only
    // decremented while non-zero, so it can never wrap. Edges that arrive
    // while a blink or its gap is running are folded into one pending bit;
    // an edge on the final gap cycle starts the next blink directly instead.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (risingEdge) begin
                    state_d = ON;
                    count_d = OnLoad;
                end
            end
            ON: begin
                if (risingEdge) begin
                    pend_d = 1'b1;
                end
                if (count_q != '0) begin
                    count_d = count_q - CountOne;
                end else begin
                    state_d = GAP;
                    count_d = OffLoad;
                end
            end
            GAP: begin
                if (count_q != '0) begin
                    count_d = count_q - CountOne;
                    if (risingEdge) begin
                        pend_d = 1'b1;
                    end
                end else if (pend_q || risingEdge) begin
                    state_d = ON;
                    count_d = OnLoad;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state and then registered, which
    // keeps led_o and busy_o cycle-aligned with each other.
    always_comb begin
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/led_stretcher.sv
// led_stretcher
// Multi-channel pulse stretcher for human-visible indicators. Every rising
// edge on a channel input gives one blink of on_cycles, followed by a dark
// gap of at least off_cycles. Channels are fully independent.
// Ports:
//   Clk       : clock, posedge
//   Rst_n     : asynchronous active-low reset
//   Pulses_in : [data_width] event inputs, synchronous to Clk
//   Leds_out  : [data_width] stretched outputs, registered
//   Busy_out  : [data_width] per-channel not-idle flags, registered
module led_stretcher #(
    parameter int data_width = 5,
    parameter int on_cycles  = 4,
    parameter int off_cycles = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [data_width-1:0] Pulses_in,
    output logic [data_width-1:0] Leds_out,
    output logic [data_width-1:0] Busy_out
);

    import led_stretcher_pkg::*;

    // One identical channel per input bit; no state is shared between them.
    for (genvar i = 0; i < data_width; i++) begin : g_chan
        led_stretcher_chan #(
            .on_cycles (on_cycles),
            .off_cycles(off_cycles)
        ) u_chan (
            .clk_i  (Clk),
            .rst_ni (Rst_n),
            .pulse_i(Pulses_in[i]),
            .led_o  (Leds_out[i]),
            .busy_o (Busy_out[i])
        );
    end

endmodule

// File: tb/tb_led_stretcher.sv
// tb_led_stretcher
// Self-checking bench for led_stretcher with on_cycles=4, off_cycles=2 and
// 5 channels. The reference model tracks, per channel, only the cycle at
// which the latest blink started and whether another blink is queued; the
// expected LED and busy levels follow from those start times.
module tb_led_stretcher;

    localparam int NumCh   = 5;
    localparam int OnCyc   = 4;
    localparam int OffCyc  = 2;
    localparam int NoStart = -1000;

    logic             Clk;
    logic             Rst_n;
    logic [NumCh-1:0] Pulses_in;
    logic [NumCh-1:0] Leds_out;
    logic [NumCh-1:0] Busy_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int               mStart[NumCh];
    bit               mPend[NumCh];
    bit               mPrev[NumCh];
    logic [NumCh-1:0] expLeds;
    logic [NumCh-1:0] expBusy;

    led_stretcher #(
        .data_width(NumCh),
        .on_cycles (OnCyc),
        .off_cycles(OffCyc)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Pulses_in(Pulses_in),
        .Leds_out (Leds_out),
        .Busy_out (Busy_out)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: forget every start time and queued event.
    function automatic void modelReset();
        for (int i = 0; i < NumCh; i++) begin
            mStart[i] = NoStart;
            mPend[i]  = 1'b0;
            mPrev[i]  = 1'b0;
        end
        expLeds = '0;
        expBusy = '0;
    endfunction

    // Reference model, one channel, one clock edge. A blink that started at
    // cycle s occupies cycles s..s+On+Off-1. Any edges inside (s, s+On+Off)
    // queue exactly one follow-up blink at s+On+Off; an edge at s+On+Off
    // itself starts that follow-up; later edges start a fresh blink.
    function automatic void modelStep(input int ch, input logic inBit);
        logic e;
        int   periodEnd;
        e = inBit & ~mPrev[ch];
        mPrev[ch] = inBit;
        periodEnd = mStart[ch] + OnCyc + OffCyc;
        if (cyc == periodEnd && (mPend[ch] || e)) begin
            mStart[ch] = cyc;
            mPend[ch]  = 1'b0;
        end else if (e && cyc > mStart[ch] && cyc < periodEnd) begin
            mPend[ch] = 1'b1;
        end else if (e) begin
            mStart[ch] = cyc;
        end
        expLeds[ch] = (cyc >= mStart[ch]) && (cyc < mStart[ch] + OnCyc);
        expBusy[ch] = (cyc >= mStart[ch]) && (cyc < mStart[ch] + OnCyc + OffCyc);
    endfunction

    // Advance one clock: the model sees the same input sample as the DUT,
    // then wait to the falling edge where outputs are stable for checking.
    task automatic tick();
        @(posedge Clk);
        cyc++;
        for (int i = 0; i < NumCh; i++) begin
            modelStep(i, Pulses_in[i]);
        end
        @(negedge Clk);
    endtask

    // Reset state, including the asynchronous assertion before any clock.
    task automatic test_reset();
        Pulses_in = '0;
        Rst_n     = 1'b0;
        modelReset();
        #1;
        checks++;
        if (Leds_out !== '0 || Busy_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_initial: leds=%b busy=%b, expected 0/0", Leds_out, Busy_out);
        end
        repeat (2) @(negedge Clk);
        checks++;
        if (Leds_out !== '0 || Busy_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held: leds=%b busy=%b, expected 0/0", Leds_out, Busy_out);
        end
        Rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                errors++;
                $display("[TB] FAIL reset_idle k=%0d: leds=%b busy=%b expected %b/%b", k, Leds_out, Busy_out, expLeds, expBusy);
            end
        end
    endtask

    // One-cycle pulse on ch0 at local cycle 10.
    task automatic test_single();
        int highCount = 0;
        int firstHigh = -1;
        logic busyAt15 = 1'b0;
        logic busyAt16 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            Pulses_in = '0;
            if (k == 10) Pulses_in[0] = 1'b1;
            tick();
            checks++;
            if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                errors++;
                $display("[TB] FAIL single_model k=%0d: leds=%b busy=%b expected %b/%b", k, Leds_out, Busy_out, expLeds, expBusy);
            end
            if (Leds_out[0] === 1'b1) begin
                highCount++;
                if (firstHigh < 0) firstHigh = k;
            end
            if (k == 15) busyAt15 = Busy_out[0];
            if (k == 16) busyAt16 = Busy_out[0];
        end
        checks++;
        if (highCount != OnCyc || firstHigh != 10) begin
            errors++;
            $display("[TB] FAIL single_shape: high=%0d first=%0d, expected %0d/10", highCount, firstHigh, OnCyc);
        end
        checks++;
        if (busyAt15 !== 1'b1 || busyAt16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_busy: busy@15=%b busy@16=%b, expected 1/0", busyAt15, busyAt16);
        end
    endtask

    // Ch1 held high for 20 cycles: one blink only, busy clear 6 cycles after rise.
    task automatic test_level();
        int highCount = 0;
        int lateBusy  = 0;
        for (int k = 0; k < 30; k++) begin
            Pulses_in = '0;
            if (k >= 2 && k < 22) Pulses_in[1] = 1'b1;
            tick();
            checks++;
            if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                errors++;
                $display("[TB] FAIL level_model k=%0d: leds=%b busy=%b expected %b/%b", k, Leds_out, Busy_out, expLeds, expBusy);
            end
            if (Leds_out[1] === 1'b1) highCount++;
            if (k >= 8 && Busy_out[1] !== 1'b0) lateBusy++;
        end
        checks++;
        if (highCount != OnCyc || lateBusy != 0) begin
            errors++;
            $display("[TB] FAIL level_shape: high=%0d late_busy=%0d, expected %0d/0", highCount, lateBusy, OnCyc);
        end
    endtask

    // Ch2: pulses at 10,12 (and 13 on the second pass) give exactly two blinks.
    task automatic test_pending();
        for (int r = 0; r < 2; r++) begin
            int   rises     = 0;
            int   secondWin = 0;
            logic prevLed   = 1'b0;
            for (int k = 0; k < 30; k++) begin
                Pulses_in = '0;
                if (k == 10 || k == 12 || (r == 1 && k == 13)) Pulses_in[2] = 1'b1;
                tick();
                checks++;
                if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                    errors++;
                    $display("[TB] FAIL pending_model r=%0d k=%0d: leds=%b busy=%b expected %b/%b", r, k, Leds_out, Busy_out, expLeds, expBusy);
                end
                if (Leds_out[2] === 1'b1 && prevLed === 1'b0) rises++;
                if (k >= 16 && k <= 19 && Leds_out[2] === 1'b1) secondWin++;
                prevLed = Leds_out[2];
            end
            checks++;
            if (rises != 2 || secondWin != OnCyc) begin
                errors++;
                $display("[TB] FAIL pending_blinks r=%0d: blinks=%0d high16_19=%0d, expected 2/%0d", r, rises, secondWin, OnCyc);
            end
        end
    endtask

    // Ch3: second pulse during the gap after a blink at 10 restarts at 16, no extra gap.
    task automatic test_last_gap();
        logic ledAt15 = 1'b1;
        logic ledAt16 = 1'b0;
        for (int k = 0; k < 25; k++) begin
            Pulses_in = '0;
            if (k == 10 || k == 15) Pulses_in[3] = 1'b1;
            tick();
            checks++;
            if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                errors++;
                $display("[TB] FAIL lastgap_model k=%0d: leds=%b busy=%b expected %b/%b", k, Leds_out, Busy_out, expLeds, expBusy);
            end
            if (k == 15) ledAt15 = Leds_out[3];
            if (k == 16) ledAt16 = Leds_out[3];
        end
        checks++;
        if (ledAt15 !== 1'b0 || ledAt16 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lastgap_restart: led@15=%b led@16=%b, expected 0/1", ledAt15, ledAt16);
        end
    endtask

    // Asynchronous reset mid-blink, then release with input low and high.
    task automatic test_reset_mid();
        int highAfter = 0;
        for (int k = 0; k < 5; k++) begin
            Pulses_in = '0;
            if (k == 2) Pulses_in[0] = 1'b1;
            if (k == 3) Pulses_in[0] = 1'b1;
            if (k == 3) Pulses_in[4] = 1'b1;
            tick();
        end
        Pulses_in = '0;
        Pulses_in[4] = 1'b1;
        #2;
        Rst_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if (Leds_out !== '0 || Busy_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async: leds=%b busy=%b, expected 0/0", Leds_out, Busy_out);
        end
        @(negedge Clk);
        Pulses_in = '0;
        Rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (Leds_out !== '0) highAfter++;
        end
        checks++;
        if (highAfter != 0 || Busy_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_discard: high_cycles=%0d busy=%b, expected 0/0", highAfter, Busy_out);
        end
        Pulses_in[4] = 1'b1;
        tick();
        tick();
        #2;
        Rst_n = 1'b0;
        modelReset();
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        checks++;
        if (Leds_out[4] !== 1'b1 || Busy_out[4] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_high_input: led4=%b busy4=%b, expected 1/1", Leds_out[4], Busy_out[4]);
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 5) Pulses_in = '0;
            tick();
            checks++;
            if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                errors++;
                $display("[TB] FAIL reset_after_model k=%0d: leds=%b busy=%b expected %b/%b", k, Leds_out, Busy_out, expLeds, expBusy);
            end
        end
    endtask

    // Simultaneous, staggered and random activity across all channels.
    task automatic test_independence();
        int allOn = 0;
        int firstHigh[NumCh];
        for (int k = 0; k < 15; k++) begin
            Pulses_in = (k == 3) ? '1 : '0;
            tick();
            checks++;
            if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                errors++;
                $display("[TB] FAIL simult_model k=%0d: leds=%b busy=%b expected %b/%b", k, Leds_out, Busy_out, expLeds, expBusy);
            end
            if (Leds_out === '1) allOn++;
        end
        checks++;
        if (allOn != OnCyc) begin
            errors++;
            $display("[TB] FAIL simult_all_on: cycles=%0d, expected %0d", allOn, OnCyc);
        end
        for (int i = 0; i < NumCh; i++) firstHigh[i] = -1;
        for (int k = 0; k < 25; k++) begin
            Pulses_in = '0;
            for (int i = 0; i < NumCh; i++) begin
                if (k == 3 + 2 * i) Pulses_in[i] = 1'b1;
            end
            tick();
            checks++;
            if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                errors++;
                $display("[TB] FAIL stagger_model k=%0d: leds=%b busy=%b expected %b/%b", k, Leds_out, Busy_out, expLeds, expBusy);
            end
            for (int i = 0; i < NumCh; i++) begin
                if (Leds_out[i] === 1'b1 && firstHigh[i] < 0) firstHigh[i] = k;
            end
        end
        for (int i = 0; i < NumCh; i++) begin
            checks++;
            if (firstHigh[i] != 3 + 2 * i) begin
                errors++;
                $display("[TB] FAIL stagger_first ch%0d: first=%0d, expected %0d", i, firstHigh[i], 3 + 2 * i);
            end
        end
        Pulses_in = '0;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NumCh; i++) begin
                if ($urandom_range(0, 4) == 0) Pulses_in[i] = ~Pulses_in[i];
            end
            tick();
            checks++;
            if (Leds_out !== expLeds || Busy_out !== expBusy) begin
                errors++;
                $display("[TB] FAIL random_model k=%0d: leds=%b busy=%b expected %b/%b", k, Leds_out, Busy_out, expLeds, expBusy);
            end
        end
        Pulses_in = '0;
        repeat (8) tick();
    endtask

    initial begin
        $display("[TB] led_stretcher bench starting");
        test_reset();
        test_single();
        test_level();
        test_pending();
        test_last_gap();
        test_reset_mid();
        test_independence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_stretcher.md
# led_stretcher

Multi-channel pulse stretcher for board LEDs and other human-visible indicators. It does the opposite of the input debouncer: the debouncer removes short pulses, and this block lengthens them. Each rising edge on a channel input produces exactly one output blink of fixed length, followed by a guaranteed dark gap. The block sits between internal single-cycle status or event strobes and the LED output pins.

## Interface
- `data_width`, default 5: number of independent channels.
- `on_cycles`, default 4: blink high time in Clk cycles; must be ≥ 1.
- `off_cycles`, default 2: minimum dark gap after each blink in Clk cycles; must be ≥ 1.
- `Clk`, input, 1: the only clock; all logic is on posedge.
- `Rst_n`, input, 1: reset, asynchronous and active-low.
- `Pulses_in`, input, `data_width`: event inputs, synchronous to Clk; any width of pulse is accepted.
- `Leds_out`, output, `data_width`: stretched outputs, registered.
- `Busy_out`, output, `data_width`: high while the channel is not IDLE, registered.

## Operation
- Channels are fully independent and identical. Channel i uses `Pulses_in[i]`, `Leds_out[i]` and `Busy_out[i]`.
- Edge detect:
  - A previous-sample register `prev`, reset to 0.
  - `edge = Pulses_in[i] & ~prev`.
  - An input held high produces one edge only.
- Per-channel state machine with states IDLE, ON and GAP, plus a down-counter `cnt` and a 1-bit `pend` flag.
  - IDLE, `Leds_out=0`:
    - on edge, go to ON with `cnt = on_cycles-1`.
  - ON, `Leds_out=1`:
    - while `cnt>0`, decrement;
    - when `cnt==0`, go to GAP with `cnt = off_cycles-1`.
    - An edge in ON sets `pend`. This includes the last ON cycle.
  - GAP, `Leds_out=0`:
    - while `cnt>0`, decrement;
    - when `cnt==0` and (`pend` or `edge`), go to ON with `cnt = on_cycles-1` and clear `pend`;
    - when `cnt==0` with neither, go to IDLE.
    - An edge in GAP before the last cycle sets `pend`.
- `pend` is a single bit and saturates. Any number of edges during one ON+GAP period yields exactly one extra blink; further edges are dropped silently.
- Counter width is `$clog2(max(on_cycles, off_cycles))`, minimum 1 bit. The counter never wraps: it is only loaded on entry to a state and decremented while it is greater than 0.
- `Busy_out[i] = (state != IDLE)`. It is computed from the next state so that it is aligned with `Leds_out`.

## Timing
- Reset (Rst_n low, asynchronous): every channel goes to IDLE; `Leds_out=0`, `Busy_out=0`, `pend=0`, `cnt=0`, `prev=0`.
- If `Pulses_in[i]` is already high at the first posedge after reset release, this counts as an edge and produces one blink.
- Latency and pulse shape for an edge sampled at posedge t with the channel in IDLE:
  - `Leds_out[i]` is high from after posedge t to after posedge t+`on_cycles`, i.e. exactly `on_cycles` cycles.
  - It is then low for exactly `off_cycles` cycles.
  - The earliest next rise is after posedge t+`on_cycles`+`off_cycles`.
- Back-to-back blinks always keep the full `off_cycles` gap; there is never a merged high.
- Reset asserted mid-blink: the output drops immediately (asynchronously), and the pending event is discarded.

## Structure
- Package `led_stretcher_pkg` holds:
  - the state encoding as a 2-bit typedef: IDLE=0, ON=1, GAP=2; the value 3 is illegal and recovers to IDLE;
  - a counter-width helper function.
- Sub-module `led_stretcher_chan` implements one channel (edge detect, FSM, counter, pend). The top level instantiates it `data_width` times in a generate loop.

## Test plan
All scenarios use `on_cycles=4` and `off_cycles=2`.
- **Single-cycle pulse** on ch0 at posedge 10:
  - `Leds_out[0]` is high after posedges 10–13 and low from 14.
  - `Busy_out[0]` is low again from posedge 16.
- **Level held high** on ch1 for 20 cycles: exactly one 4-cycle blink; `Busy_out[1]` is 0 from 6 cycles after the rise onward.
- **Pending behaviour** on ch2:
  - pulses at posedges 10 and 12 give blinks at 10–13 and 16–19;
  - adding a third pulse at 13 still gives only two blinks.
- **Edge on the last GAP cycle**: a pulse exactly at posedge 15 after a blink started at 10 gives the next ON starting at posedge 16 with no extra gap.
- **Reset mid-operation**:
  - `Rst_n` low asynchronously during ON drives `Leds_out` and `Busy_out` to 0 before the next clock;
  - after release, with the input low, there are no blinks; with the input high, there is one blink starting at the first posedge.
- **Channel independence**: simultaneous and staggered pulses on all 5 channels give each channel a waveform identical to its solo run.
